// File: rtl/axis_eth_frame_source.sv
// Test-frame source for one 32-bit AXI-Stream TX lane. Each frame carries a
// programmed Ethernet header, a 32-bit sequence number and an incrementing
// byte payload. FCS is left to the downstream MAC.
module axis_eth_frame_source #(
  parameter int unsigned MAX_FRAME_LEN = 1514,
  parameter int unsigned MIN_FRAME_LEN = 60
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_len,
  input  logic [15:0] frame_count,
  input  logic [7:0]  ifg_cycles,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  output logic        axi_tx_tvalid,
  input  logic        axi_tx_tready,
  output logic [31:0] axi_tx_tdata,
  output logic [3:0]  axi_tx_tkeep,
  output logic        axi_tx_tlast,
  output logic        axi_tx_tuser,
  output logic        busy,
  output logic        done,
  output logic [31:0] frames_sent
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [7:0]  gap_q, gap_d;
  // Sequence number and frames_sent are the same count: both clear on start
  // and step on every tlast handshake.
  logic [31:0] seq_q, seq_d;
  logic        stop_pend_q, stop_pend_d;
  logic        done_q, done_d;

  // Burst configuration, captured once per accepted start.
  logic [15:0] len_q;
  logic [15:0] last_beat_q;
  logic [15:0] count_q;
  logic [7:0]  ifg_q;
  logic [47:0] dst_q, src_q;
  logic [15:0] eth_q;

  logic [15:0] len_clamped;
  logic [15:0] len_round;
  logic        cfg_load;
  logic        handshake;
  logic        last_beat;
  logic        stop_now;
  logic        burst_end;
  logic [31:0] seq_inc;

  assign cfg_load  = (state_q == StIdle) && start && !stop;
  assign handshake = axi_tx_tvalid && axi_tx_tready;
  assign last_beat = (beat_q == last_beat_q);
  assign stop_now  = stop_pend_q || stop;
  assign seq_inc   = seq_q + 32'd1;
  assign burst_end = (count_q != 16'd0) && (seq_inc == {16'd0, count_q});
  assign len_round = len_clamped + 16'd3;

  // Clamp the requested length into the legal frame range.
  always_comb begin
    len_clamped = frame_len;
    if (frame_len < 16'(MIN_FRAME_LEN)) begin
      len_clamped = 16'(MIN_FRAME_LEN);
    end else if (frame_len > 16'(MAX_FRAME_LEN)) begin
      len_clamped = 16'(MAX_FRAME_LEN);
    end
  end

  // Latch configuration on start acceptance; later changes are ignored.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      len_q       <= 16'd0;
      last_beat_q <= 16'd0;
      count_q     <= 16'd0;
      ifg_q       <= 8'd0;
      dst_q       <= 48'd0;
      src_q       <= 48'd0;
      eth_q       <= 16'd0;
    end else if (cfg_load) begin
      len_q       <= len_clamped;
      last_beat_q <= (len_round >> 2) - 16'd1;
      count_q     <= frame_count;
      ifg_q       <= ifg_cycles;
      dst_q       <= dst_mac;
      src_q       <= src_mac;
      eth_q       <= ethertype;
    end
  end

  // FSM and counter state register.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q     <= StIdle;
      beat_q      <= 16'd0;
      gap_q       <= 8'd0;
      seq_q       <= 32'd0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      seq_q       <= seq_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: frame sequencing, gap timing, stop and burst end.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    seq_d       = seq_q;
    stop_pend_d = stop_pend_q || (stop && (state_q != StIdle));
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d     = StSend;
          beat_d      = 16'd0;
          seq_d       = 32'd0;
          stop_pend_d = 1'b0;
        end
      end
      StSend: begin
        if (handshake) begin
          if (last_beat) begin
            beat_d = 16'd0;
            seq_d  = seq_inc;
            if (burst_end || stop_now) begin
              state_d     = StIdle;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else if (ifg_q != 8'd0) begin
              state_d = StGap;
              gap_d   = ifg_q;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      StGap: begin
        if (gap_q <= 8'd1) begin
          gap_d = 8'd0;
          if (stop_now) begin
            state_d     = StIdle;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = StSend;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Beat assembly: header+sequence for bytes 0-17, then payload (k-18) mod 256.
  // Outputs derive only from registered state, so they hold during stalls.
  always_comb begin
    logic [143:0] hdr;
    logic [17:0]  k;
    logic [17:0]  pay;
    logic [7:0]   byte_v;
    int           idx;
    hdr          = {dst_q, src_q, eth_q, seq_q};
    axi_tx_tdata = 32'd0;
    axi_tx_tkeep = 4'd0;
    k            = 18'd0;
    pay          = 18'd0;
    byte_v       = 8'd0;
    idx          = 0;
    if (state_q == StSend) begin
      for (int l = 0; l < 4; l++) begin
        k = {beat_q, 2'b00} + 18'(l);
        if (k < {2'b00, len_q}) begin
          if (k < 18'd18) begin
            idx    = 8 * (17 - int'(k));
            byte_v = hdr[idx +: 8];
          end else begin
            pay    = k - 18'd18;
            byte_v = pay[7:0];
          end
          axi_tx_tkeep[l]        = 1'b1;
          axi_tx_tdata[8*l +: 8] = byte_v;
        end
      end
    end
  end

  assign axi_tx_tvalid = (state_q == StSend);
  assign axi_tx_tlast  = (state_q == StSend) && last_beat;
  assign axi_tx_tuser  = 1'b0;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign frames_sent   = seq_q;

endmodule

// File: tb/tb_axis_eth_frame_source.sv
// Directed bench for axis_eth_frame_source: table of burst vectors checked
// beat-by-beat against a byte model, plus reset and start/stop corner cases.
module tb_axis_eth_frame_source;

  localparam logic [47:0] DST = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SRC = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [15:0] ETH = 16'h88B5;
  localparam int BUDGET = 4000;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        start, stop;
  logic [15:0] frame_len, frame_count;
  logic [7:0]  ifg_cycles;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype;
  logic        tvalid, tready, tlast, tuser, busy, done;
  logic [31:0] tdata, frames_sent;
  logic [3:0]  tkeep;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  axis_eth_frame_source dut (
    .aclk          (aclk),
    .areset_n      (areset_n),
    .start         (start),
    .stop          (stop),
    .frame_len     (frame_len),
    .frame_count   (frame_count),
    .ifg_cycles    (ifg_cycles),
    .dst_mac       (dst_mac),
    .src_mac       (src_mac),
    .ethertype     (ethertype),
    .axi_tx_tvalid (tvalid),
    .axi_tx_tready (tready),
    .axi_tx_tdata  (tdata),
    .axi_tx_tkeep  (tkeep),
    .axi_tx_tlast  (tlast),
    .axi_tx_tuser  (tuser),
    .busy          (busy),
    .done          (done),
    .frames_sent   (frames_sent)
  );

  typedef struct {
    logic [15:0] frame_len;
    logic [15:0] count;
    logic [7:0]  ifg;
    bit          rnd;
    int          eff_len;
    int          beats;
    logic [3:0]  last_keep;
    int          frames;
    int          stop_frame;
    bit          stop_gap;
    bit          disturb;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int k, input logic [31:0] seq);
    logic [47:0] d;
    logic [47:0] s;
    logic [15:0] e;
    logic [31:0] q;
    d = DST;
    s = SRC;
    e = ETH;
    if (k < 6) begin
      d = d >> (40 - 8 * k);
      return d[7:0];
    end else if (k < 12) begin
      s = s >> (40 - 8 * (k - 6));
      return s[7:0];
    end else if (k == 12) begin
      return e[15:8];
    end else if (k == 13) begin
      return e[7:0];
    end else if (k < 18) begin
      q = seq >> (24 - 8 * (k - 14));
      return q[7:0];
    end
    return 8'((k - 18) % 256);
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int beat = 0, frame = 0, idle = 0, hs = 0, done_cnt = 0, post = 0;
    bit counting = 0, done_seen = 0, prev_stall = 0, stop_sent = 0, dist_sent = 0;
    bit rdy;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
    int          k;
    frame_len   = v.frame_len;
    frame_count = v.count;
    ifg_cycles  = v.ifg;
    dst_mac     = DST;
    src_mac     = SRC;
    ethertype   = ETH;
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    check($sformatf("v%0d start_valid", id), tvalid, 1);
    check($sformatf("v%0d start_busy", id), busy, 1);
    for (int cyc = 0; cyc < BUDGET && post < 8; cyc++) begin
      start = 1'b0;
      stop  = 1'b0;
      if (done_seen) post++;
      if (done) begin
        done_cnt++;
        done_seen = 1;
        check($sformatf("v%0d done_busy", id), busy, 0);
      end
      if (prev_stall) check($sformatf("v%0d valid_held", id), tvalid, 1);
      rdy    = v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      tready = rdy;
      if (tvalid) begin
        if (done_seen || frame >= v.frames) begin
          check($sformatf("v%0d extra_beat", id), tvalid, 0);
        end else begin
          if (counting) begin
            check($sformatf("v%0d ifg_len", id), idle, v.ifg);
            counting = 0;
          end
          exp_last = (beat == v.beats - 1);
          exp_keep = exp_last ? v.last_keep : 4'hF;
          exp_data = 32'd0;
          for (int l = 0; l < 4; l++) begin
            k = 4 * beat + l;
            if (k < v.eff_len) exp_data[8*l +: 8] = ref_byte(k, 32'(frame));
          end
          check($sformatf("v%0d f%0d b%0d tdata", id, frame, beat), tdata, exp_data);
          check($sformatf("v%0d f%0d b%0d tkeep", id, frame, beat), tkeep, exp_keep);
          check($sformatf("v%0d f%0d b%0d tlast", id, frame, beat), tlast, exp_last);
          check($sformatf("v%0d tuser", id), tuser, 0);
          if (!v.stop_gap && frame == v.stop_frame && beat == 5 && !stop_sent) begin
            stop      = 1'b1;
            stop_sent = 1;
          end
          if (v.disturb && frame == 0 && beat == 2 && !dist_sent) begin
            frame_len   = 16'd200;
            frame_count = 16'd5;
            dst_mac     = 48'd0;
            src_mac     = 48'd0;
            start       = 1'b1;
            dist_sent   = 1;
          end
          if (rdy) begin
            hs++;
            if (exp_last) begin
              frame++;
              beat     = 0;
              counting = 1;
              idle     = 0;
            end else begin
              beat++;
            end
          end
        end
      end else if (counting) begin
        if (v.stop_gap && frame == v.stop_frame && !stop_sent) begin
          stop      = 1'b1;
          stop_sent = 1;
        end
        idle++;
      end
      prev_stall = tvalid && !rdy;
      @(negedge aclk);
    end
    start     = 1'b0;
    stop      = 1'b0;
    tready    = 1'b1;
    dst_mac   = DST;
    src_mac   = SRC;
    check($sformatf("v%0d done_pulses", id), done_cnt, 1);
    check($sformatf("v%0d frames_sent", id), frames_sent, v.frames);
    check($sformatf("v%0d frames_seen", id), frame, v.frames);
    check($sformatf("v%0d handshakes", id), hs, v.frames * v.beats);
    check($sformatf("v%0d busy_end", id), busy, 0);
  endtask

  initial begin
    //        len    cnt ifg rnd  L     beats keep  frm stopf gap dist
    vecs[0] = '{16'd64,   16'd3, 8'd0,  0, 64,   16,  4'hF, 3, -1, 0, 0};
    vecs[1] = '{16'd61,   16'd1, 8'd0,  0, 61,   16,  4'h1, 1, -1, 0, 0};
    vecs[2] = '{16'd10,   16'd1, 8'd0,  0, 60,   15,  4'hF, 1, -1, 0, 0};
    vecs[3] = '{16'd1514, 16'd2, 8'd0,  1, 1514, 379, 4'h3, 2, -1, 0, 0};
    vecs[4] = '{16'd2000, 16'd1, 8'd2,  0, 1514, 379, 4'h3, 1, -1, 0, 0};
    vecs[5] = '{16'd63,   16'd2, 8'd3,  1, 63,   16,  4'h7, 2, -1, 0, 0};
    vecs[6] = '{16'd64,   16'd0, 8'd12, 0, 64,   16,  4'hF, 5, 4,  0, 0};
    vecs[7] = '{16'd62,   16'd0, 8'd4,  0, 62,   16,  4'h3, 2, 2,  1, 0};
    vecs[8] = '{16'd64,   16'd1, 8'd0,  0, 64,   16,  4'hF, 1, -1, 0, 1};

    areset_n    = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    frame_len   = 16'd64;
    frame_count = 16'd1;
    ifg_cycles  = 8'd0;
    dst_mac     = DST;
    src_mac     = SRC;
    ethertype   = ETH;
    tready      = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst tvalid", tvalid, 0);
    check("rst tlast", tlast, 0);
    check("rst tuser", tuser, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst tdata", tdata, 0);
    check("rst tkeep", tkeep, 0);
    check("rst frames_sent", frames_sent, 0);
    areset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // start and stop together in idle: stop wins, nothing is sent
    @(negedge aclk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop busy", busy, 0);
    check("startstop tvalid", tvalid, 0);
    repeat (3) @(negedge aclk);
    check("startstop tvalid_later", tvalid, 0);
    check("startstop done", done, 0);

    // reset in the middle of the third frame of a continuous burst
    frame_len   = 16'd60;
    frame_count = 16'd0;
    ifg_cycles  = 8'd0;
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (38) @(negedge aclk);
    check("prerst frames_sent", frames_sent, 2);
    check("prerst tvalid", tvalid, 1);
    areset_n = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1;
    check("midrst tvalid", tvalid, 0);
    check("midrst busy", busy, 0);
    check("midrst frames_sent", frames_sent, 0);
    check("midrst tlast", tlast, 0);
    check("midrst tkeep", tkeep, 0);
    check("midrst done", done, 0);
    run_vec(vecs[0], 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
